axi4lite_buffered_bridge: RTL and testbench
===========================================

// Module: axi4lite_buffered_bridge
// PURPOSE
//  AXI4-Lite slave-to-master pass-through bridge, next generation of the core AXI4-Lite bridge.
//  Every channel (AW, W, B, AR, R) is decoupled by its own parametrised FIFO, so throughput is one beat per cycle.
//  Outstanding reads and writes are each capped at a programmable limit and counted.
//  Sits between the core's load/store unit (slave side) and the system interconnect (master side).
// PARAMETERS
//  ADDR_WIDTH      64               address width, AW/AR channels
//  DATA_WIDTH      64               data width, W/R channels; 32 or 64
//  STRB_WIDTH      DATA_WIDTH/8     write strobe width (one bit per byte)
//  DEPTH           2                entries per channel FIFO; power of two, >=2
//  MAX_OUTSTANDING 4                maximum reads and maximum writes in flight; >=1
//  CW              $clog2(MAX_OUTSTANDING+1)  counter width (localparam)
// PORTS
//  axi_clk         in   1           clock; all logic on rising edge
//  axi_rst         in   1           synchronous reset, active-high
//  saxi_aw{addr,prot,valid,ready}   in/in/in/out  ADDR_WIDTH/3/1/1    slave write address
//  saxi_w{data,strb,valid,ready}    in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  slave write data
//  saxi_b{resp,valid,ready}         out/out/in    2/1/1               slave write response
//  saxi_ar{addr,prot,valid,ready}   in/in/in/out  ADDR_WIDTH/3/1/1    slave read address
//  saxi_r{data,resp,valid,ready}    out/out/out/in  DATA_WIDTH/2/1/1  slave read data
//  maxi_aw*, maxi_w*, maxi_b*, maxi_ar*, maxi_r*   mirror of slave ports with directions reversed
//  rd_outstanding  out  CW          reads accepted on saxi_ar, R not yet delivered on saxi_r
//  wr_outstanding  out  CW          writes accepted on saxi_aw, B not yet delivered on saxi_b
//  idle            out  1           all FIFOs empty and both counters zero
// BEHAVIOUR
//  Reset (axi_rst=1 at a rising edge): all FIFOs empty, pointers and counters 0, storage cleared to 0.
//   Every valid and ready output is 0 while axi_rst=1. Data/addr/resp/prot/strb outputs are 0. idle=1.
//   Reset mid-transaction flushes all in-flight beats without completing them.
//   First cycle after release: all readies reflect FIFO state (1 if not throttled).
//  Channel FIFO, one per channel, DEPTH entries, count 0..DEPTH:
//   Input ready = !full. Output valid = !empty. Output payload = head entry (registered, no comb in->out path).
//   Push on in_valid&&in_ready; pop on out_valid&&out_ready; simultaneous push+pop leaves count unchanged.
//   Latency: beat accepted at edge N is presented on the far side from edge N onward (1 cycle); no bypass.
//   Full: ready=0 even if a pop occurs that cycle. Empty: valid=0.
//   Pointers wrap modulo DEPTH.
//  Directions:
//   AW: saxi->maxi, payload {addr,prot}. W: saxi->maxi, payload {data,strb}.
//   AR: saxi->maxi, payload {addr,prot}. B: maxi->saxi, payload {resp}. R: maxi->saxi, payload {data,resp}.
//   Responses pass unmodified; SLVERR/DECERR are forwarded, not generated.
//  Outstanding limit:
//   saxi_arready = !ar_full && (rd_outstanding < MAX_OUTSTANDING).
//   saxi_awready = !aw_full && (wr_outstanding < MAX_OUTSTANDING).
//   rd_outstanding: +1 on saxi AR handshake, -1 on saxi R handshake; both in one cycle = no change.
//   wr_outstanding: same rule with saxi AW (increment) and saxi B (decrement).
//   W is not throttled; AW/W order independence is preserved, with no coupling between the AW and W FIFOs.
//   Counters never exceed MAX_OUTSTANDING. Underflow (response with counter=0) must not occur.
//   Simulation assertion flags underflow; the counter saturates at 0.
//  idle is combinational from registered state.
// TESTING
//  1 Reset: assert axi_rst 2 cycles with saxi_arvalid=1 -> all readies/valids 0; after release saxi_arready=1, idle=1.
//  2 Single read: AR addr 0x1000 at edge N -> maxi_arvalid=1, araddr=0x1000 at N+1.
//    Slave returns rdata=0xDEADBEEF_CAFEF00D, rresp=00 -> saxi_rvalid 1 cycle later, rd_outstanding 1->0.
//  3 Back-to-back writes, DEPTH=2, maxi_awready=maxi_wready=0:
//    2 AW + 2 W accepted, 3rd sees saxi_awready=0 and saxi_wready=0.
//    Releasing readies drains in order at 1 beat/cycle.
//  4 Outstanding cap, MAX_OUTSTANDING=4, maxi_rvalid held 0:
//    4 reads accepted, 5th stalls with saxi_arready=0, rd_outstanding=4.
//    One R delivered -> saxi_arready=1 next cycle.
//  5 Simultaneous AR accept and R deliver at rd_outstanding=2 -> stays 2.
//    Full FIFO with push+pop in same cycle -> count unchanged, no data loss.
//  6 Reset mid-burst: 3 writes in flight, axi_rst pulsed 1 cycle -> counters 0, FIFOs empty, no maxi_bready/valid glitch.
//    Also run with bresp=10 forwarded -> saxi_bresp=10.

Source files
------------

// File: rtl/axi4lite_buffered_bridge_if.sv
// AXI4-Lite bus bundle shared by the slave (load/store unit) and master
// (interconnect) sides of the buffered bridge.
interface axi4lite_buffered_bridge_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    // Issues requests, accepts responses.
    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    // Accepts requests, returns responses.
    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );
endinterface

// File: rtl/axi4lite_buffered_bridge.sv
// AXI4-Lite pass-through bridge: every channel runs through its own small
// FIFO, and reads/writes in flight are capped and counted.

// Single-clock FIFO with registered storage; the head entry drives the output,
// so there is never a combinational path from input to output.
module axi4lite_buffered_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic             full;
    logic             push;
    logic             pop;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    // Handshakes are forced low while reset is held so nothing moves.
    assign in_ready  = !full && !srst;
    assign out_valid = !empty && !srst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = srst ? '0 : mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Each entry clears on reset and captures when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

module axi4lite_buffered_bridge #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     axi_clk,
    input  logic                                     axi_rst,
    axi4lite_buffered_bridge_if.slave                saxi,
    axi4lite_buffered_bridge_if.master               maxi,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     rd_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     wr_outstanding,
    output logic                                     idle
);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam int AW_W = ADDR_WIDTH + 3;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH;
    localparam int B_W  = 2;
    localparam int R_W  = DATA_WIDTH + 2;

    logic [CW-1:0] rd_outstanding_reg;
    logic [CW-1:0] wr_outstanding_reg;
    logic          rd_room;
    logic          wr_room;
    logic          ar_hs, r_hs, aw_hs, b_hs;

    logic             aw_in_ready, ar_in_ready;
    logic             aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic [AW_W-1:0]  aw_out_data;
    logic [W_W-1:0]   w_out_data;
    logic [B_W-1:0]   b_out_data;
    logic [AW_W-1:0]  ar_out_data;
    logic [R_W-1:0]   r_out_data;

    assign rd_room = (rd_outstanding_reg < MAX_CNT);
    assign wr_room = (wr_outstanding_reg < MAX_CNT);

    // Write address: throttled by the outstanding-write cap.
    axi4lite_buffered_bridge_fifo #(.WIDTH(AW_W), .DEPTH(DEPTH)) u_aw_fifo (
        .clk(axi_clk), .srst(axi_rst),
        .in_valid(saxi.awvalid && wr_room), .in_ready(aw_in_ready),
        .in_data({saxi.awaddr, saxi.awprot}),
        .out_valid(maxi.awvalid), .out_ready(maxi.awready),
        .out_data(aw_out_data), .empty(aw_empty)
    );
    assign saxi.awready = aw_in_ready && wr_room;
    assign {maxi.awaddr, maxi.awprot} = aw_out_data;

    // Write data: never throttled, independent of the AW path.
    axi4lite_buffered_bridge_fifo #(.WIDTH(W_W), .DEPTH(DEPTH)) u_w_fifo (
        .clk(axi_clk), .srst(axi_rst),
        .in_valid(saxi.wvalid), .in_ready(saxi.wready),
        .in_data({saxi.wdata, saxi.wstrb}),
        .out_valid(maxi.wvalid), .out_ready(maxi.wready),
        .out_data(w_out_data), .empty(w_empty)
    );
    assign {maxi.wdata, maxi.wstrb} = w_out_data;

    // Write response: forwarded unmodified back to the slave side.
    axi4lite_buffered_bridge_fifo #(.WIDTH(B_W), .DEPTH(DEPTH)) u_b_fifo (
        .clk(axi_clk), .srst(axi_rst),
        .in_valid(maxi.bvalid), .in_ready(maxi.bready),
        .in_data(maxi.bresp),
        .out_valid(saxi.bvalid), .out_ready(saxi.bready),
        .out_data(b_out_data), .empty(b_empty)
    );
    assign saxi.bresp = b_out_data;

    // Read address: throttled by the outstanding-read cap.
    axi4lite_buffered_bridge_fifo #(.WIDTH(AW_W), .DEPTH(DEPTH)) u_ar_fifo (
        .clk(axi_clk), .srst(axi_rst),
        .in_valid(saxi.arvalid && rd_room), .in_ready(ar_in_ready),
        .in_data({saxi.araddr, saxi.arprot}),
        .out_valid(maxi.arvalid), .out_ready(maxi.arready),
        .out_data(ar_out_data), .empty(ar_empty)
    );
    assign saxi.arready = ar_in_ready && rd_room;
    assign {maxi.araddr, maxi.arprot} = ar_out_data;

    // Read data: forwarded unmodified back to the slave side.
    axi4lite_buffered_bridge_fifo #(.WIDTH(R_W), .DEPTH(DEPTH)) u_r_fifo (
        .clk(axi_clk), .srst(axi_rst),
        .in_valid(maxi.rvalid), .in_ready(maxi.rready),
        .in_data({maxi.rdata, maxi.rresp}),
        .out_valid(saxi.rvalid), .out_ready(saxi.rready),
        .out_data(r_out_data), .empty(r_empty)
    );
    assign {saxi.rdata, saxi.rresp} = r_out_data;

    assign ar_hs = saxi.arvalid && saxi.arready;
    assign r_hs  = saxi.rvalid  && saxi.rready;
    assign aw_hs = saxi.awvalid && saxi.awready;
    assign b_hs  = saxi.bvalid  && saxi.bready;

    // Reads in flight: up on AR accept, down on R delivery, floor at zero.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            rd_outstanding_reg <= '0;
        end else if (ar_hs && !r_hs) begin
            rd_outstanding_reg <= rd_outstanding_reg + CW'(1);
        end else if (!ar_hs && r_hs && (rd_outstanding_reg != '0)) begin
            rd_outstanding_reg <= rd_outstanding_reg - CW'(1);
        end
    end

    // Writes in flight: up on AW accept, down on B delivery, floor at zero.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            wr_outstanding_reg <= '0;
        end else if (aw_hs && !b_hs) begin
            wr_outstanding_reg <= wr_outstanding_reg + CW'(1);
        end else if (!aw_hs && b_hs && (wr_outstanding_reg != '0)) begin
            wr_outstanding_reg <= wr_outstanding_reg - CW'(1);
        end
    end

    assign rd_outstanding = rd_outstanding_reg;
    assign wr_outstanding = wr_outstanding_reg;

    assign idle = axi_rst ||
                  (aw_empty && w_empty && b_empty && ar_empty && r_empty &&
                   (rd_outstanding_reg == '0) && (wr_outstanding_reg == '0));

    // A response with nothing outstanding means the interconnect misbehaved.
    a_rd_underflow: assert property (@(posedge axi_clk) disable iff (axi_rst)
        !(r_hs && !ar_hs && (rd_outstanding_reg == '0)));
    a_wr_underflow: assert property (@(posedge axi_clk) disable iff (axi_rst)
        !(b_hs && !aw_hs && (wr_outstanding_reg == '0)));
endmodule

// File: tb/tb_axi4lite_buffered_bridge.sv
// Directed bench for the buffered AXI4-Lite bridge: a cycle table for the
// read path plus hand-written sequences for backpressure, the outstanding
// cap, and reset in mid-flight.
module tb_axi4lite_buffered_bridge;
    logic       axi_clk = 1'b0;
    logic       axi_rst;
    logic [2:0] rd_outstanding;
    logic [2:0] wr_outstanding;
    logic       idle;

    int n_vec = 0;
    int n_bad = 0;

    axi4lite_buffered_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s_if ();
    axi4lite_buffered_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_if ();

    axi4lite_buffered_bridge #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .STRB_WIDTH(8),
        .DEPTH(2), .MAX_OUTSTANDING(4)
    ) dut (
        .axi_clk(axi_clk),
        .axi_rst(axi_rst),
        .saxi(s_if),
        .maxi(m_if),
        .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding),
        .idle(idle)
    );

    always #5 axi_clk = ~axi_clk;

    // Fields: inputs first, then expected outputs.
    typedef struct {
        logic        ar_valid;
        logic [63:0] ar_addr;
        logic        m_ar_ready;
        logic        m_r_valid;
        logic [63:0] m_r_data;
        logic [1:0]  m_r_resp;
        logic        s_r_ready;
        logic        e_ar_ready;
        logic        e_m_ar_valid;
        logic [63:0] e_m_ar_addr;
        logic        e_m_r_ready;
        logic        e_r_valid;
        logic [63:0] e_r_data;
        logic [1:0]  e_r_resp;
        logic [2:0]  e_rd_out;
        logic        e_idle;
    } rd_vec_t;

    localparam int NV = 10;
    rd_vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awprot = '0;
        s_if.wvalid  = 1'b0; s_if.wdata  = '0; s_if.wstrb  = '0;
        s_if.bready  = 1'b1;
        s_if.arvalid = 1'b0; s_if.araddr = '0; s_if.arprot = '0;
        s_if.rready  = 1'b1;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.bvalid  = 1'b0; m_if.bresp  = '0;
        m_if.rvalid  = 1'b0; m_if.rdata  = '0; m_if.rresp = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Read-path cycle table.
        vecs[0] = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 3'd0, 1'b1};
        vecs[1] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h0, 2'd0, 3'd1, 1'b0};
        vecs[2] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 3'd1, 1'b0};
        vecs[3] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b0,
                    1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 2'd0, 3'd1, 1'b0};
        vecs[4] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 2'd0, 3'd1, 1'b0};
        vecs[5] = '{1'b1, 64'h2000_0000_0000_0008, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 3'd0, 1'b1};
        vecs[6] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b1, 64'h2000_0000_0000_0008, 1'b1, 1'b0, 64'h0, 2'd0, 3'd1, 1'b0};
        vecs[7] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b10, 1'b1,
                    1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h0, 2'd0, 3'd1, 1'b0};
        vecs[8] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h1000, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b10, 3'd1, 1'b0};
        vecs[9] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1,
                    1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 2'd0, 3'd0, 1'b1};

        // Reset held two cycles with a read request pending.
        idle_inputs();
        axi_rst = 1'b1;
        s_if.arvalid = 1'b1; s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
        m_if.bvalid = 1'b1; m_if.rvalid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rst%0d.s_arready", c), 64'(s_if.arready), 64'd0);
            chk($sformatf("rst%0d.s_awready", c), 64'(s_if.awready), 64'd0);
            chk($sformatf("rst%0d.s_wready", c),  64'(s_if.wready),  64'd0);
            chk($sformatf("rst%0d.m_bready", c),  64'(m_if.bready),  64'd0);
            chk($sformatf("rst%0d.m_rready", c),  64'(m_if.rready),  64'd0);
            chk($sformatf("rst%0d.m_arvalid", c), 64'(m_if.arvalid), 64'd0);
            chk($sformatf("rst%0d.s_rvalid", c),  64'(s_if.rvalid),  64'd0);
            chk($sformatf("rst%0d.m_awaddr", c),  m_if.awaddr,       64'd0);
            chk($sformatf("rst%0d.idle", c),      64'(idle),         64'd1);
            tick();
        end
        axi_rst = 1'b0;
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
        #1;
        chk("rel.s_arready", 64'(s_if.arready), 64'd1);
        chk("rel.idle",      64'(idle),         64'd1);
        s_if.arvalid = 1'b0;
        tick();

        // Read path, one table row per cycle.
        for (int i = 0; i < NV; i++) begin
            s_if.arvalid = vecs[i].ar_valid;
            s_if.araddr  = vecs[i].ar_addr;
            m_if.arready = vecs[i].m_ar_ready;
            m_if.rvalid  = vecs[i].m_r_valid;
            m_if.rdata   = vecs[i].m_r_data;
            m_if.rresp   = vecs[i].m_r_resp;
            s_if.rready  = vecs[i].s_r_ready;
            #1;
            chk($sformatf("rd[%0d].s_arready", i), 64'(s_if.arready), 64'(vecs[i].e_ar_ready));
            chk($sformatf("rd[%0d].m_arvalid", i), 64'(m_if.arvalid), 64'(vecs[i].e_m_ar_valid));
            chk($sformatf("rd[%0d].m_araddr", i),  m_if.araddr,       vecs[i].e_m_ar_addr);
            chk($sformatf("rd[%0d].m_rready", i),  64'(m_if.rready),  64'(vecs[i].e_m_r_ready));
            chk($sformatf("rd[%0d].s_rvalid", i),  64'(s_if.rvalid),  64'(vecs[i].e_r_valid));
            chk($sformatf("rd[%0d].s_rdata", i),   s_if.rdata,        vecs[i].e_r_data);
            chk($sformatf("rd[%0d].s_rresp", i),   64'(s_if.rresp),   64'(vecs[i].e_r_resp));
            chk($sformatf("rd[%0d].rd_out", i),    64'(rd_outstanding), 64'(vecs[i].e_rd_out));
            chk($sformatf("rd[%0d].idle", i),      64'(idle),         64'(vecs[i].e_idle));
            tick();
        end

        // Two writes fill AW and W while the interconnect stalls; the third waits.
        idle_inputs();
        s_if.awvalid = 1'b1; s_if.awaddr = 64'h100; s_if.awprot = 3'b010;
        s_if.wvalid  = 1'b1; s_if.wdata  = 64'h1111_2222_3333_4444; s_if.wstrb = 8'hFF;
        #1;
        chk("wr1.s_awready", 64'(s_if.awready), 64'd1);
        chk("wr1.s_wready",  64'(s_if.wready),  64'd1);
        tick();
        s_if.awaddr = 64'h108; s_if.awprot = 3'b000;
        s_if.wdata  = 64'h5555_6666_7777_8888; s_if.wstrb = 8'h0F;
        #1;
        chk("wr2.s_awready", 64'(s_if.awready), 64'd1);
        chk("wr2.s_wready",  64'(s_if.wready),  64'd1);
        chk("wr2.m_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("wr2.m_awaddr",  m_if.awaddr,       64'h100);
        chk("wr2.wr_out",    64'(wr_outstanding), 64'd1);
        tick();
        s_if.awaddr = 64'h110; s_if.wdata = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        chk("wr3.s_awready", 64'(s_if.awready), 64'd0);
        chk("wr3.s_wready",  64'(s_if.wready),  64'd0);
        chk("wr3.wr_out",    64'(wr_outstanding), 64'd2);
        tick();
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("drn1.m_awaddr", m_if.awaddr,      64'h100);
        chk("drn1.m_awprot", 64'(m_if.awprot), 64'd2);
        chk("drn1.m_wdata",  m_if.wdata,       64'h1111_2222_3333_4444);
        chk("drn1.m_wstrb",  64'(m_if.wstrb),  64'hFF);
        tick();
        #1;
        chk("drn2.m_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("drn2.m_awaddr",  m_if.awaddr,       64'h108);
        chk("drn2.m_wdata",   m_if.wdata,        64'h5555_6666_7777_8888);
        chk("drn2.m_wstrb",   64'(m_if.wstrb),   64'h0F);
        tick();
        m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
        #1;
        chk("drn3.m_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("drn3.m_wvalid",  64'(m_if.wvalid),  64'd0);
        chk("drn3.m_bready",  64'(m_if.bready),  64'd1);
        tick();
        m_if.bresp = 2'b10;
        #1;
        chk("b1.s_bvalid", 64'(s_if.bvalid), 64'd1);
        chk("b1.s_bresp",  64'(s_if.bresp),  64'd0);
        chk("b1.wr_out",   64'(wr_outstanding), 64'd2);
        tick();
        m_if.bvalid = 1'b0;
        #1;
        chk("b2.s_bvalid", 64'(s_if.bvalid), 64'd1);
        chk("b2.s_bresp",  64'(s_if.bresp),  64'd2);
        chk("b2.wr_out",   64'(wr_outstanding), 64'd1);
        tick();
        #1;
        chk("b3.s_bvalid", 64'(s_if.bvalid), 64'd0);
        chk("b3.wr_out",   64'(wr_outstanding), 64'd0);
        chk("b3.idle",     64'(idle),           64'd1);

        // Outstanding-read cap with no read data returning.
        idle_inputs();
        m_if.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_if.arvalid = 1'b1; s_if.araddr = 64'h3000 + 64'(i * 8);
            #1;
            chk($sformatf("cap%0d.s_arready", i), 64'(s_if.arready), 64'd1);
            chk($sformatf("cap%0d.rd_out", i),    64'(rd_outstanding), 64'(i));
            tick();
        end
        #1;
        chk("cap4.s_arready", 64'(s_if.arready), 64'd0);
        chk("cap4.rd_out",    64'(rd_outstanding), 64'd4);
        tick();
        m_if.rvalid = 1'b1; m_if.rdata = 64'hAA; s_if.rready = 1'b0;
        #1;
        chk("cap5.s_arready", 64'(s_if.arready), 64'd0);
        tick();
        m_if.rdata = 64'hBB;
        #1;
        chk("cap6.s_rvalid", 64'(s_if.rvalid), 64'd1);
        chk("cap6.s_rdata",  s_if.rdata,       64'hAA);
        chk("cap6.rd_out",   64'(rd_outstanding), 64'd4);
        tick();
        m_if.rdata = 64'hCC; s_if.rready = 1'b1;
        #1;
        chk("full_pop.m_rready", 64'(m_if.rready), 64'd0);
        tick();
        s_if.arvalid = 1'b0;
        #1;
        chk("cap8.s_arready", 64'(s_if.arready), 64'd1);
        chk("cap8.rd_out",    64'(rd_outstanding), 64'd3);
        chk("cap8.s_rdata",   s_if.rdata,        64'hBB);
        chk("cap8.m_rready",  64'(m_if.rready),  64'd1);
        tick();
        m_if.rvalid = 1'b0;
        s_if.arvalid = 1'b1; s_if.araddr = 64'h4000;
        #1;
        chk("sim.rd_out_before", 64'(rd_outstanding), 64'd2);
        chk("sim.s_rdata",       s_if.rdata,        64'hCC);
        chk("sim.s_arready",     64'(s_if.arready), 64'd1);
        tick();
        s_if.arvalid = 1'b0;
        #1;
        chk("sim.rd_out_after", 64'(rd_outstanding), 64'd2);
        chk("sim.s_rvalid",     64'(s_if.rvalid),    64'd0);

        // Reset pulse with three writes in flight.
        idle_inputs();
        m_if.awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_if.awvalid = 1'b1; s_if.awaddr = 64'h500 + 64'(i * 8);
            s_if.wvalid  = 1'b1; s_if.wdata  = 64'hF00 + 64'(i);
            s_if.wstrb = 8'hFF;
            #1;
            chk($sformatf("mid%0d.s_awready", i), 64'(s_if.awready), 64'd1);
            tick();
        end
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        #1;
        chk("mid.wr_out", 64'(wr_outstanding), 64'd3);
        axi_rst = 1'b1;
        #1;
        chk("midrst.m_wvalid",  64'(m_if.wvalid),  64'd0);
        chk("midrst.m_wdata",   m_if.wdata,        64'd0);
        chk("midrst.m_bready",  64'(m_if.bready),  64'd0);
        chk("midrst.s_awready", 64'(s_if.awready), 64'd0);
        chk("midrst.idle",      64'(idle),         64'd1);
        tick();
        axi_rst = 1'b0;
        #1;
        chk("post.wr_out",   64'(wr_outstanding), 64'd0);
        chk("post.rd_out",   64'(rd_outstanding), 64'd0);
        chk("post.idle",     64'(idle),           64'd1);
        chk("post.m_wvalid", 64'(m_if.wvalid),    64'd0);
        chk("post.m_bready", 64'(m_if.bready),    64'd1);
        chk("post.s_awready", 64'(s_if.awready),  64'd1);

        // One write after reset, returning SLVERR.
        idle_inputs();
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        s_if.awvalid = 1'b1; s_if.awaddr = 64'h700;
        s_if.wvalid  = 1'b1; s_if.wdata  = 64'h77; s_if.wstrb = 8'h01;
        tick();
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        #1;
        chk("err.m_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("err.m_awaddr",  m_if.awaddr,       64'h700);
        tick();
        m_if.bvalid = 1'b1; m_if.bresp = 2'b10;
        tick();
        m_if.bvalid = 1'b0;
        #1;
        chk("err.s_bvalid", 64'(s_if.bvalid), 64'd1);
        chk("err.s_bresp",  64'(s_if.bresp),  64'd2);
        chk("err.wr_out",   64'(wr_outstanding), 64'd1);
        tick();
        #1;
        chk("err.wr_out_done", 64'(wr_outstanding), 64'd0);
        chk("err.idle",        64'(idle),           64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
